// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the control unit.
// Holds the PC, issues single-outstanding req/ack reads to instruction
// memory, and queues fetched words in a small prefetch FIFO. Fetching
// stops after a halt word. A redirect reloads the PC and flushes the FIFO.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 pulse: leave IDLE and begin fetching
//   redirect, redirect_pc pulse: flush buffer, pc <= redirect_pc
//   imem_req, imem_addr   registered read request / address (held until ack)
//   imem_ack, imem_data   read completion and returned word
//   inst_valid/ready      head-of-buffer handshake to the control unit
//   inst_word/opcode/pc   head entry, its opcode field and fetch address
//   halted                halt fetched, buffer drained, nothing outstanding
module fetch_unit #(
  parameter int unsigned         ADDR_W   = 8,
  parameter int unsigned         INST_W   = 16,
  parameter int unsigned         DEPTH    = 2,
  parameter logic [ADDR_W-1:0]   PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_word,
  output logic [3:0]        inst_opcode,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              halted
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned OPC_W   = 4;
  localparam logic [OPC_W-1:0] OP_HALT = 4'd5;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                req_q, req_d;
  logic                discard_q, discard_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [INST_W-1:0]   word_mem_q [DEPTH];
  logic [INST_W-1:0]   word_mem_d [DEPTH];
  logic [ADDR_W-1:0]   pc_mem_q   [DEPTH];
  logic [ADDR_W-1:0]   pc_mem_d   [DEPTH];

  logic pop_c;
  logic ack_c;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= PC_RESET;
      addr_q    <= PC_RESET;
      req_q     <= 1'b0;
      discard_q <= 1'b0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        word_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      word_mem_q <= word_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end

  // Next-state: redirect, ack/enqueue, pop, request issue
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    word_mem_d = word_mem_q;
    pc_mem_d   = pc_mem_q;

    pop_c = (count_q != '0) && inst_ready;
    ack_c = req_q && imem_ack;

    if (redirect && (state_q != S_IDLE)) begin
      state_d  = S_FETCH;
      pc_d     = redirect_pc;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      // An in-flight read must still complete; its word is dropped.
      if (req_q && !imem_ack) begin
        discard_d = 1'b1;
      end else begin
        req_d     = 1'b0;
        discard_d = 1'b0;
      end
    end else begin
      if (state_q == S_IDLE) begin
        if (redirect) pc_d = redirect_pc;
        if (start) state_d = S_FETCH;
      end

      if (ack_c) begin
        req_d = 1'b0;
        if (discard_q) begin
          discard_d = 1'b0;
        end else begin
          word_mem_d[wr_ptr_q] = imem_data;
          pc_mem_d[wr_ptr_q]   = pc_q;
          wr_ptr_d             = wr_ptr_q + PTR_W'(1);
          count_d              = count_d + CNT_W'(1);
          pc_d                 = pc_q + ADDR_W'(1);
          if (imem_data[INST_W-1 -: OPC_W] == OP_HALT) state_d = S_HALT;
        end
      end

      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d  = count_d - CNT_W'(1);
      end

      // Issue back-to-back with an ack when a slot is (or becomes) free.
      if ((state_q == S_FETCH) && (state_d == S_FETCH) && !req_d &&
          (count_d < CNT_W'(DEPTH))) begin
        req_d  = 1'b1;
        addr_d = pc_d;
      end
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign inst_valid  = (count_q != '0);
  assign inst_word   = word_mem_q[rd_ptr_q];
  assign inst_opcode = word_mem_q[rd_ptr_q][INST_W-1 -: OPC_W];
  assign inst_pc     = pc_mem_q[rd_ptr_q];
  assign halted      = (state_q == S_HALT) && (count_q == '0) && !req_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven decode/ordering check
// plus directed sequences for backpressure, wrap, redirect, halt and reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, redirect;
  logic [7:0]  redirect_pc;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        inst_valid, inst_ready, halted;
  logic [15:0] inst_word;
  logic [3:0]  inst_opcode;
  logic [7:0]  inst_pc;

  // Second instance with PC_RESET near the top of the address space.
  logic        rst2_n, start2;
  logic        imem_req2, imem_ack2;
  logic [7:0]  imem_addr2;
  logic [15:0] imem_data2;
  logic        inst_valid2, halted2;
  logic        inst_ready2;
  logic        redirect2;
  logic [7:0]  redirect_pc2;
  logic [15:0] inst_word2;
  logic [3:0]  inst_opcode2;
  logic [7:0]  inst_pc2;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(8), .INST_W(16), .DEPTH(2), .PC_RESET(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_word(inst_word), .inst_opcode(inst_opcode),
    .inst_pc(inst_pc), .halted(halted)
  );

  fetch_unit #(.ADDR_W(8), .INST_W(16), .DEPTH(2), .PC_RESET(8'hFE)) dut2 (
    .clk(clk), .rst_n(rst2_n), .start(start2), .redirect(redirect2),
    .redirect_pc(redirect_pc2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_data(imem_data2), .inst_valid(inst_valid2),
    .inst_ready(inst_ready2), .inst_word(inst_word2), .inst_opcode(inst_opcode2),
    .inst_pc(inst_pc2), .halted(halted2)
  );

  // Zero-wait all-noop memory for the second instance.
  assign imem_ack2  = imem_req2;
  assign imem_data2 = 16'h0000;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] word;
    logic [3:0]  opc;
  } pop_t;

  typedef struct {
    logic [15:0] word;
    logic [3:0]  opc;
    logic [7:0]  pc;
  } vec_t;

  logic [15:0] mem [256];
  int          wait_cycles = 0;
  int          wcnt = 0;
  logic [7:0]  ack_q  [$];
  logic [7:0]  ack2_q [$];
  pop_t        pop_q  [$];
  int          n_chk  = 0;
  int          n_fail = 0;

  // Memory model: acks after wait_cycles idle cycles of a held request.
  always @(negedge clk) begin
    if (!rst_n) begin
      wcnt = 0;
      imem_ack = 1'b0;
    end else if (imem_req) begin
      if (wcnt >= wait_cycles) begin
        imem_ack  = 1'b1;
        imem_data = mem[imem_addr];
        wcnt = 0;
      end else begin
        imem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wcnt = 0;
    end
  end

  // Monitor: log completed reads and pops just before the edge that acts on them.
  always @(negedge clk) begin
    #2;
    if (rst_n && imem_req && imem_ack) ack_q.push_back(imem_addr);
    if (rst_n && inst_valid && inst_ready) pop_q.push_back({inst_pc, inst_word, inst_opcode});
    if (rst2_n && imem_req2 && imem_ack2) ack2_q.push_back(imem_addr2);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic pulse_redirect(input logic [7:0] target);
    redirect = 1'b1;
    redirect_pc = target;
    tick();
    redirect = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    ack_q.delete();
    pop_q.delete();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    rst_n = 1'b1;
    tick();
  endtask

  vec_t tbl [8];

  initial begin
    bit stale;
    bit found;
    int guard;

    rst_n = 1'b0; rst2_n = 1'b0;
    start = 1'b0; start2 = 1'b0;
    redirect = 1'b0; redirect_pc = 8'h00;
    redirect2 = 1'b0; redirect_pc2 = 8'h00;
    inst_ready = 1'b0; inst_ready2 = 1'b1;
    imem_ack = 1'b0; imem_data = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    tbl[0] = '{16'h3123, 4'd3,  8'h00};
    tbl[1] = '{16'h4456, 4'd4,  8'h01};
    tbl[2] = '{16'h6777, 4'd6,  8'h02};
    tbl[3] = '{16'hF00F, 4'd15, 8'h03};
    tbl[4] = '{16'h0000, 4'd0,  8'h04};
    tbl[5] = '{16'h1ABC, 4'd1,  8'h05};
    tbl[6] = '{16'h2DEF, 4'd2,  8'h06};
    tbl[7] = '{16'h5000, 4'd5,  8'h07};

    // Reset values while rst_n is held low
    #12;
    check("rst_req",    32'(imem_req),    32'd0);
    check("rst_addr",   32'(imem_addr),   32'd0);
    check("rst_valid",  32'(inst_valid),  32'd0);
    check("rst_word",   32'(inst_word),   32'd0);
    check("rst_opcode", 32'(inst_opcode), 32'd0);
    check("rst_pc",     32'(inst_pc),     32'd0);
    check("rst_halted", 32'(halted),      32'd0);
    do_reset();

    // A: zero-wait memory, table of words ending in halt, ready held high
    for (int i = 0; i < 8; i++) mem[i] = tbl[i].word;
    wait_cycles = 0;
    inst_ready = 1'b1;
    pulse_start();
    check("start_req_n", 32'(imem_req), 32'd0);
    tick();
    check("start_req_n1", 32'(imem_req), 32'd1);
    check("start_addr",   32'(imem_addr), 32'd0);
    guard = 0;
    while (pop_q.size() < 8 && guard < 40) begin tick(); guard++; end
    check("tbl_pop_count", 32'(pop_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < pop_q.size()) begin
        check($sformatf("tbl%0d_pc", i),   32'(pop_q[i].pc),   32'(tbl[i].pc));
        check($sformatf("tbl%0d_word", i), 32'(pop_q[i].word), 32'(tbl[i].word));
        check($sformatf("tbl%0d_opc", i),  32'(pop_q[i].opc),  32'(tbl[i].opc));
      end
    end
    repeat (5) tick();
    check("halt_no_more_fetch", 32'(ack_q.size()), 32'd8);
    check("halt_req_low",       32'(imem_req),     32'd0);
    check("halted_after_pop",   32'(halted),       32'd1);

    // B: 3-wait memory with ready low fills exactly DEPTH entries
    inst_ready = 1'b0;
    do_reset();
    wait_cycles = 3;
    pulse_start();
    guard = 0;
    while (ack_q.size() < 2 && guard < 40) begin tick(); guard++; end
    repeat (10) tick();
    check("full_ack_count", 32'(ack_q.size()), 32'd2);
    check("full_req_low",   32'(imem_req),     32'd0);
    check("full_valid",     32'(inst_valid),   32'd1);
    check("full_head_pc",   32'(inst_pc),      32'd0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    guard = 0;
    while (ack_q.size() < 3 && guard < 40) begin tick(); guard++; end
    check("resume_ack_count", 32'(ack_q.size()), 32'd3);
    if (ack_q.size() >= 3) check("resume_addr", 32'(ack_q[2]), 32'd2);

    // C: redirect while a 2-wait read of 0x05 (a halt word) is outstanding
    do_reset();
    mem[8'h05] = 16'h5000;
    mem[8'h40] = 16'h3040;
    mem[8'h41] = 16'h5000;
    mem[8'h10] = 16'h2010;
    wait_cycles = 2;
    pulse_redirect(8'h05);
    pulse_start();
    tick();
    check("idle_redir_req",  32'(imem_req),  32'd1);
    check("idle_redir_addr", 32'(imem_addr), 32'h05);
    pulse_redirect(8'h40);
    check("redir_hold_req",  32'(imem_req),   32'd1);
    check("redir_hold_addr", 32'(imem_addr),  32'h05);
    check("redir_flush",     32'(inst_valid), 32'd0);
    stale = 1'b0;
    found = 1'b0;
    guard = 0;
    while (!(found && inst_valid) && guard < 20) begin
      tick();
      guard++;
      found = 1'b0;
      foreach (ack_q[k]) if (ack_q[k] == 8'h40) found = 1'b1;
      if (inst_valid && !found) stale = 1'b1;
    end
    check("redir_no_stale", 32'(stale), 32'd0);
    check("redir_ack_seen", 32'(found), 32'd1);
    if (ack_q.size() >= 2) begin
      check("discard_addr",   32'(ack_q[0]), 32'h05);
      check("redir_new_addr", 32'(ack_q[1]), 32'h40);
    end
    check("redir_head_pc",  32'(inst_pc),     32'h40);
    check("redir_head_opc", 32'(inst_opcode), 32'd3);

    // D: redirect out of HALT
    inst_ready = 1'b1;
    guard = 0;
    while (!halted && guard < 30) begin tick(); guard++; end
    check("halt_reached", 32'(halted),   32'd1);
    check("halt_req",     32'(imem_req), 32'd0);
    pulse_redirect(8'h10);
    check("unhalt", 32'(halted), 32'd0);
    pop_q.delete();
    guard = 0;
    while (pop_q.size() < 1 && guard < 20) begin tick(); guard++; end
    if (pop_q.size() >= 1) begin
      check("unhalt_pop_pc",   32'(pop_q[0].pc),   32'h10);
      check("unhalt_pop_word", 32'(pop_q[0].word), 32'h2010);
    end else begin
      check("unhalt_pop_seen", 32'(pop_q.size()), 32'd1);
    end

    // E: asynchronous reset with an entry buffered and a read in flight
    inst_ready = 1'b0;
    wait_cycles = 3;
    guard = 0;
    while (!(inst_valid && imem_req && !imem_ack) && guard < 40) begin tick(); guard++; end
    check("pre_rst_busy", 32'(inst_valid && imem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req",   32'(imem_req),   32'd0);
    check("async_rst_valid", 32'(inst_valid), 32'd0);
    tick();
    ack_q.delete();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_idle_req", 32'(imem_req),  32'd0);
    check("post_rst_addr",     32'(imem_addr), 32'd0);
    pulse_start();
    guard = 0;
    while (ack_q.size() < 1 && guard < 20) begin tick(); guard++; end
    if (ack_q.size() >= 1) check("post_rst_pc", 32'(ack_q[0]), 32'd0);
    else check("post_rst_ack_seen", 32'(ack_q.size()), 32'd1);

    // F: PC wrap on the PC_RESET=0xFE instance, one fetch per cycle
    rst2_n = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b1;
    tick();
    start2 = 1'b0;
    guard = 0;
    while (ack2_q.size() < 4 && guard < 20) begin tick(); guard++; end
    check("wrap_count", 32'(ack2_q.size() >= 4), 32'd1);
    check("wrap_cycles", 32'(guard <= 5), 32'd1);
    if (ack2_q.size() >= 4) begin
      check("wrap0", 32'(ack2_q[0]), 32'hFE);
      check("wrap1", 32'(ack2_q[1]), 32'hFF);
      check("wrap2", 32'(ack2_q[2]), 32'h00);
      check("wrap3", 32'(ack2_q[3]), 32'h01);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
